// File: rtl/conv_enc_pkg.sv
// Shared constants and types for the K=7 rate-1/2 convolutional encoder.
package conv_enc_pkg;

    localparam int unsigned K        = 7;
    localparam int unsigned MEM      = 6;
    localparam int unsigned TAIL_LEN = 6;

    localparam logic [6:0] G0_DEFAULT = 7'o171;
    localparam logic [6:0] G1_DEFAULT = 7'o133;

    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } enc_state_t;

endpackage

// File: rtl/conv_enc_parity.sv
// One generator tap: XOR-reduce the encoder window masked by a polynomial.
module conv_enc_parity (
    input  logic [6:0] window,
    input  logic [6:0] poly,
    output logic       parity
);

    always_comb begin
        parity = ^(window & poly);
    end

endmodule

// File: rtl/conv_encoder_k7.sv
// K=7 rate-1/2 convolutional encoder with a single-entry output register.
// CONV_ENC_TAIL_FLUSH_EN adds a 6-symbol zero tail after each in_last.
module conv_encoder_k7
    import conv_enc_pkg::*;
#(
    parameter logic [6:0] G0_POLY = G0_DEFAULT,
    parameter logic [6:0] G1_POLY = G1_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_bit,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [1:0] out_pair,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       tail_active
);

    logic [MEM-1:0] s;
    logic [K-1:0]   window;
    logic           u;
    logic           advance;
    logic           accept;
    logic           load;
    logic           p0;
    logic           p1;

    conv_enc_parity u_par0 (
        .window (window),
        .poly   (G0_POLY),
        .parity (p0)
    );

    conv_enc_parity u_par1 (
        .window (window),
        .poly   (G1_POLY),
        .parity (p1)
    );

`ifdef CONV_ENC_TAIL_FLUSH_EN
    enc_state_t state;
    logic [2:0] tcnt;
    logic       tail_q;

    always_comb begin
        advance  = !out_valid || out_ready;
        in_ready = advance && (state == DATA);
        accept   = in_valid && in_ready;
        load     = accept || ((state == TAIL) && advance);
        u        = (state == TAIL) ? 1'b0 : in_bit;
        window   = {u, s};
    end

    // tail_active is registered with the symbol so it describes what is on out_pair.
    assign tail_active = tail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= DATA;
            tcnt      <= '0;
            s         <= '0;
            out_pair  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            tail_q    <= 1'b0;
        end else if (load) begin
            s         <= window[K-1:1];
            out_pair  <= {p1, p0};
            out_valid <= 1'b1;
            if (state == DATA) begin
                tail_q   <= 1'b0;
                out_last <= 1'b0;
                if (in_last) begin
                    state <= TAIL;
                    tcnt  <= '0;
                end
            end else begin
                tail_q <= 1'b1;
                if (tcnt == 3'(TAIL_LEN - 1)) begin
                    out_last <= 1'b1;
                    state    <= DATA;
                    tcnt     <= '0;
                end else begin
                    out_last <= 1'b0;
                    tcnt     <= tcnt + 3'd1;
                end
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            tail_q    <= 1'b0;
        end
    end
`else
    always_comb begin
        advance  = !out_valid || out_ready;
        in_ready = advance;
        accept   = in_valid && in_ready;
        load     = accept;
        u        = in_bit;
        window   = {u, s};
    end

    assign tail_active = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s         <= '0;
            out_pair  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            s         <= window[K-1:1];
            out_pair  <= {p1, p0};
            out_valid <= 1'b1;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/conv_encoder_k7.md
# conv_encoder_k7

Rate-1/2, constraint-length-7 convolutional encoder. It is the transmit-side counterpart of the 64-state Viterbi decoder's branch-metric/ACS datapath. It accepts one information bit per handshake and emits one 2-bit coded pair per handshake. At the end of each frame it optionally appends zero tail bits, so the decoder's traceback terminates in state 0. Each output pair uses the same bit ordering the decoder's branch-metric units consume on `rx_pair`.

## Interface

Parameters:
- `G0_POLY`, default 7'o171: generator for `out_pair[0]`; bit 6 taps the current input, bit 0 taps the oldest stored bit.
- `G1_POLY`, default 7'o133: generator for `out_pair[1]`; same bit mapping as `G0_POLY`.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_bit` in 1: information bit.
- `in_valid` in 1: `in_bit` / `in_last` are valid.
- `in_last` in 1: this bit is the last bit of the frame.
- `in_ready` out 1: encoder accepts an input this cycle.
- `out_pair` out 2: coded symbol; [0] = G0 parity, [1] = G1 parity.
- `out_valid` out 1: `out_pair` / `out_last` are valid.
- `out_last` out 1: last symbol of the frame, including tail.
- `out_ready` in 1: downstream accepts the symbol.
- `tail_active` out 1: encoder is emitting tail symbols.

## Operation

- State `s[5:0]`, reset to 0. Window `w[6:0] = {u, s[5:0]}`, where `u` is the current bit.
- Parities: `p0 = ^(w & G0_POLY)`, `p1 = ^(w & G1_POLY)`.
- Next state: `s <= w[6:1]`.
- `advance = !out_valid || out_ready`. This is a single-entry output register with pass-through on pop.
- FSM states:
  - DATA:
    - `in_ready = advance`.
    - On `in_valid && in_ready`: `u = in_bit`; load `{p1,p0}` into `out_pair`; set `out_valid = 1`.
    - If `in_last` and tail is compiled in: `out_last = 0`; go to TAIL with `tcnt = 0`.
    - Otherwise: `out_last = in_last`.
    - No acceptance and `out_ready`: `out_valid` clears.
  - TAIL:
    - `in_ready = 0`; `tail_active = 1`.
    - On each `advance`: `u = 0`; load the symbol; `tcnt++`.
    - On the 6th tail symbol (`tcnt == 5`): `out_last = 1`; return to DATA. `s` is then 0 by construction.
- Continuous streams (`in_last` never asserted) are legal; there is no implicit frame boundary.
- `in_valid` without `in_ready` is a stall, not an error.
- Input values are ignored while `in_ready = 0`.

## Timing

- Reset values:
  - State DATA, `s = 0`, `tcnt = 0`.
  - `out_valid = 0`, `out_pair = 2'b00`, `out_last = 0`.
  - `in_ready` follows `advance` (1 after reset).
  - `tail_active = 0`.
- Latency: a symbol is visible the cycle after its input bit is accepted, and is fully registered.
- Throughput: one symbol per cycle when `out_ready` is held high.
- A frame of N bits yields N+6 symbols (tail on) or N symbols (tail off).
- Tail occupies exactly 6 advancing cycles, with `in_ready = 0` throughout. The first bit of the next frame can be accepted on the cycle the last tail symbol is loaded plus one.
- Stalls:
  - `out_valid && !out_ready` holds `out_pair` / `out_last` stable.
  - `s` and `tcnt` do not advance during a stall.
- Asynchronous reset mid-frame or mid-tail: all state and outputs return to reset values immediately. There is no partial tail and no `out_last`.

## Configuration

- `CONV_ENC_TAIL_FLUSH_EN` defined:
  - Zero-tail termination as above.
  - `out_last` marks the final tail symbol.
- Undefined:
  - TAIL state and `tcnt` are not built; `tail_active` is tied to 0.
  - `out_last` mirrors the accepted `in_last`.
  - `s` is not cleared between frames; the encoder runs continuously.

## Structure

- Package `conv_enc_pkg`:
  - `K = 7`, `MEM = 6`.
  - Default `G0` / `G1` polynomials.
  - `TAIL_LEN = 6`.
  - FSM enum `{DATA, TAIL}`.
- Sub-module `conv_enc_parity`: combinational, inputs window[6:0] and poly[6:0], output one parity bit. Instantiated twice.

## Test plan

- Impulse: after reset, send one frame of the single bit 1 with `in_last`, `out_ready` high. Required: 7 symbols, `out_pair` = 11, 01, 11, 11, 00, 10, 11. `out_last` on the 7th only. `tail_active` is high for symbols 2–7.
- All-zero frame of 10 bits: required 16 symbols, all 00, `out_last` on the 16th. `in_ready` is low for the 6 tail-load cycles.
- Backpressure: random `out_ready` duty around 30% with the impulse frame. Required: identical symbol sequence, no drops or duplicates, and `out_pair` stable while stalled.
- Back-to-back frames "1" then "1", `in_valid` held high. Required: the second frame's bit is accepted only after the tail completes. Both frames produce the impulse sequence, because the state is 0 at each frame start.
- Reset mid-tail: assert `rst_n` low after the 3rd tail symbol. Required: `out_valid = 0`, `out_last = 0`, `in_ready = 1` after release. A following impulse frame reproduces the impulse sequence.
- Without `CONV_ENC_TAIL_FLUSH_EN`: bits 1, 0 (last), then 0. Required: symbols 11, 01 (`out_last`), then 11.
